// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - scrolling multi-digit hex driver for active-low 7-segment displays
module hex_display_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            nibble_in,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic                  lz_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [7*N_DIGITS-1:0] seg_out,
    output logic [3:0]            digits_loaded
);

    localparam int             CW       = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(BLINK_DIV - 1);
    localparam logic [3:0]     LOAD_MAX = 4'(N_DIGITS);
    localparam logic [6:0]     BLANK    = 7'b1111111;

    logic [N_DIGITS-1:0][3:0] dig_q, dig_d;
    logic [3:0]               loaded_q, loaded_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     phase_q, phase_d;
    logic [7*N_DIGITS-1:0]    seg_q, seg_d;
    logic                     nz;

    function automatic logic [6:0] encode(input logic [3:0] v);
        case (v)
            4'h0: encode = 7'b1000000;
            4'h1: encode = 7'b1111001;
            4'h2: encode = 7'b0100100;
            4'h3: encode = 7'b0110000;
            4'h4: encode = 7'b0011001;
            4'h5: encode = 7'b0010010;
            4'h6: encode = 7'b0000010;
            4'h7: encode = 7'b1111000;
            4'h8: encode = 7'b0000000;
            4'h9: encode = 7'b0010000;
            4'hA: encode = 7'b0001000;
            4'hB: encode = 7'b0000011;
            4'hC: encode = 7'b1000110;
            4'hD: encode = 7'b0100001;
            4'hE: encode = 7'b0000110;
            default: encode = 7'b0001110;
        endcase
    endfunction

    // Clear is applied first so a simultaneous shift lands on an empty buffer.
    always_comb begin
        dig_d    = dig_q;
        loaded_d = loaded_q;
        if (clear) begin
            dig_d    = '0;
            loaded_d = '0;
        end
        if (shift_en) begin
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                dig_d[i] = dig_d[i-1];
            end
            dig_d[0] = nibble_in;
            loaded_d = (loaded_d < LOAD_MAX) ? loaded_d + 4'd1 : LOAD_MAX;
        end
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // nz accumulates from the top digit down: a digit is a leading zero when it and everything above it is zero.
    always_comb begin
        seg_d = '1;
        nz    = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nz = nz | (|dig_q[i]);
            if (!phase_q && blink_mask[i]) begin
                seg_d[7*i +: 7] = BLANK;
            end else if (lz_en && (i > 0) && !nz) begin
                seg_d[7*i +: 7] = BLANK;
            end else begin
                seg_d[7*i +: 7] = encode(dig_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_q    <= '0;
            loaded_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            seg_q    <= '1;
        end else begin
            dig_q    <= dig_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
        end
    end

    assign seg_out       = seg_q;
    assign digits_loaded = loaded_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl (4 digits, blink divider 4)
module tb_hex_display_ctrl;

    localparam int N  = 4;
    localparam int BD = 4;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] DA = 7'b0001000;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  nibble_in;
    logic        shift_en;
    logic        clear;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [27:0] seg_out;
    logic [3:0]  digits_loaded;

    always #5 clk = ~clk;

    hex_display_ctrl #(.N_DIGITS(N), .BLINK_DIV(BD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nibble_in    (nibble_in),
        .shift_en     (shift_en),
        .clear        (clear),
        .lz_en        (lz_en),
        .blink_mask   (blink_mask),
        .seg_out      (seg_out),
        .digits_loaded(digits_loaded)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  m_buf [N];
    logic [3:0]  m_loaded;
    int          m_cnt;
    logic        m_phase;
    logic [27:0] sb_seg [$];
    logic [3:0]  sb_ld  [$];

    typedef struct {
        logic        rst;
        logic        shift;
        logic        clr;
        logic [3:0]  nib;
        logic        lz;
        logic [3:0]  mask;
        logic [3:0]  exp_ld;
        logic        chk;
        logic [27:0] exp_seg;
    } vec_t;

    vec_t vt [$];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    function automatic logic [27:0] model_seg();
        logic [27:0] r;
        logic        above;
        r     = '1;
        above = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            above = above | (m_buf[i] != 4'h0);
            if (!m_phase && blink_mask[i])   r[7*i +: 7] = BL;
            else if (lz_en && i > 0 && !above) r[7*i +: 7] = BL;
            else                              r[7*i +: 7] = seg7(m_buf[i]);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock edge: the model predicts what the DUT registers at this edge, then the scoreboard compares.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            sb_seg.push_back(28'hFFFFFFF);
            for (int i = 0; i < N; i++) m_buf[i] = 4'h0;
            m_loaded = 4'd0;
            m_cnt    = 0;
            m_phase  = 1'b1;
        end else begin
            sb_seg.push_back(model_seg());
            if (clear) begin
                for (int i = 0; i < N; i++) m_buf[i] = 4'h0;
                m_loaded = 4'd0;
            end
            if (shift_en) begin
                for (int i = N - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                m_buf[0] = nibble_in;
                m_loaded = (m_loaded < 4'(N)) ? m_loaded + 4'd1 : 4'(N);
            end
            if (m_cnt == BD - 1) begin
                m_cnt   = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
        sb_ld.push_back(m_loaded);
        #1;
        check("sb_seg", {4'h0, seg_out}, {4'h0, sb_seg.pop_front()});
        check("sb_loaded", {28'h0, digits_loaded}, {28'h0, sb_ld.pop_front()});
    endtask

    task automatic drive(input logic r, input logic s, input logic c, input logic [3:0] nib,
                         input logic lz, input logic [3:0] mask);
        rst_n      = r;
        shift_en   = s;
        clear      = c;
        nibble_in  = nib;
        lz_en      = lz;
        blink_mask = mask;
    endtask

    initial begin
        int blanks;
        int hex3_changes;
        logic [6:0] hex3_first;

        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 4'h0, 4'd1, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 4'h0, 4'd2, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 4'h0, 4'd3, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h4, 1'b0, 4'h0, 4'd4, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 4'h0, 4'd4, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'd4, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'd4, 1'b1, {D2, D3, D4, D5}});
        vt.push_back('{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 4'd0, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'd0, 1'b1, {BL, BL, BL, D0}});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'd1, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 4'h0, 4'd2, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'd2, 1'b1, {BL, BL, BL, DA}});
        vt.push_back('{1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0, 4'd1, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'd1, 1'b1, {D0, D0, D0, D7}});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 4'h0, 4'd2, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'd3, 1'b0, 28'h0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'd3, 1'b1, {BL, D7, D3, D0}});

        // Reset held for two edges, then released with no strobes.
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        cycle();
        cycle();
        check("reset_seg", {4'h0, seg_out}, 32'h0FFFFFFF);
        check("reset_loaded", {28'h0, digits_loaded}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        cycle();
        check("post_reset_zeros", {4'h0, seg_out}, {4'h0, D0, D0, D0, D0});

        for (int k = 0; k < vt.size(); k++) begin
            drive(vt[k].rst, vt[k].shift, vt[k].clr, vt[k].nib, vt[k].lz, vt[k].mask);
            cycle();
            check($sformatf("tbl%0d_loaded", k), {28'h0, digits_loaded}, {28'h0, vt[k].exp_ld});
            if (vt[k].chk)
                check($sformatf("tbl%0d_seg", k), {4'h0, seg_out}, {4'h0, vt[k].exp_seg});
        end

        // Blink on HEX0 only: over 16 edges it is blank for exactly 8, HEX3 never moves.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0001);
        blanks       = 0;
        hex3_changes = 0;
        cycle();
        hex3_first = seg_out[27:21];
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (seg_out[6:0] == BL) blanks++;
            if (seg_out[27:21] != hex3_first) hex3_changes++;
        end
        check("blink_blank_count", blanks, 8);
        check("blink_hex3_steady", hex3_changes, 0);

        // Reset landing in a blink-off phase during a shift burst.
        for (int k = 0; k < 10 && m_phase; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'(k + 1), 1'b0, 4'b0001);
            cycle();
        end
        check("reached_blink_off", {31'h0, m_phase}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'hE, 1'b0, 4'b0001);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 4'b0001);
        cycle();
        check("midburst_reset_seg", {4'h0, seg_out}, 32'h0FFFFFFF);
        check("midburst_reset_loaded", {28'h0, digits_loaded}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0001);
        cycle();
        check("no_stale_digit", {4'h0, seg_out}, {4'h0, D0, D0, D0, D0});
        cycle();
        check("phase_visible_after_reset", {4'h0, seg_out}, {4'h0, D0, D0, D0, D0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
